// File: rtl/riscv_pkg.sv
// Shared pipeline types for the MEM stage: memory op encoding, EX/MEM and MEM/WB payloads, FSM states.
package riscv_pkg;

    localparam int unsigned XLEN_W     = 32;
    localparam int unsigned REG_ADDR_W = 5;

    // Encoding follows the RISC-V load/store funct3 field.
    typedef enum logic [2:0] {
        MEM_BYTE   = 3'b000,
        MEM_HALF   = 3'b001,
        MEM_WORD   = 3'b010,
        MEM_BYTE_U = 3'b100,
        MEM_HALF_U = 3'b101
    } mem_op_t;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } mem_size_t;

    typedef struct packed {
        logic    reg_write;
        logic    mem_to_reg;
        logic    mem_read;
        logic    mem_write;
        mem_op_t mem_op;
    } ctrl_t;

    typedef struct packed {
        logic [XLEN_W-1:0]     alu_result;
        logic [XLEN_W-1:0]     rs2_data;
        logic [REG_ADDR_W-1:0] rd_addr;
        ctrl_t                 ctrl;
    } ex_mem_reg_t;

    typedef struct packed {
        logic [XLEN_W-1:0]     alu_result;
        logic [XLEN_W-1:0]     mem_data;
        logic [REG_ADDR_W-1:0] rd_addr;
        ctrl_t                 ctrl;
    } mem_wb_reg_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_RSP,
        DONE
    } mem_state_t;

    function automatic mem_size_t mem_size(input mem_op_t op);
        case (op)
            MEM_BYTE, MEM_BYTE_U: return SZ_BYTE;
            MEM_HALF, MEM_HALF_U: return SZ_HALF;
            default:              return SZ_WORD;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_stage_load_align.sv
// Load data lane select and sign/zero extension (combinational).
module load_align
    import riscv_pkg::*;
(
    input  logic [XLEN_W-1:0] i_rdata,
    input  logic [1:0]        i_addr_lo,
    input  mem_op_t           i_mem_op,
    output logic [XLEN_W-1:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
        case (i_mem_op)
            MEM_BYTE:   o_data = {{24{w_byte[7]}}, w_byte};
            MEM_BYTE_U: o_data = {24'h0, w_byte};
            MEM_HALF:   o_data = {{16{w_half[15]}}, w_half};
            MEM_HALF_U: o_data = {16'h0, w_half};
            default:    o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: data-bus request/response handshake, store lane generation, load alignment.
// Optional macro MEM_MISALIGN_TRAP_EN turns misaligned half/word accesses into a trap instead of a bus request.
module mem_access_stage
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  ex_mem_reg_t       in,
    input  logic              hold,
    output mem_wb_reg_t       out,
    output logic              mem_stall,
    output logic              dmem_req_valid,
    input  logic              dmem_req_ready,
    output logic [XLEN-1:0]   dmem_req_addr,
    output logic              dmem_req_we,
    output logic [XLEN/8-1:0] dmem_req_be,
    output logic [XLEN-1:0]   dmem_req_wdata,
    input  logic              dmem_rsp_valid,
    input  logic [XLEN-1:0]   dmem_rsp_rdata,
    output logic              misalign_trap
);

    mem_state_t        r_state;
    mem_state_t        w_state_nx;
    logic [XLEN-1:0]   r_rdata_buf;
    logic [XLEN-1:0]   w_rdata_sel;
    logic [XLEN-1:0]   w_load_data;
    logic [XLEN/8-1:0] w_be;
    logic [XLEN-1:0]   w_wdata;
    logic              w_mem_op;
    logic              w_is_load;
    logic              w_is_store;
    logic              w_misalign;
    logic              w_req_valid;
    logic              w_stall;
    logic              w_load_done;

    assign w_is_load  = in.ctrl.mem_read;
    assign w_is_store = in.ctrl.mem_write & ~in.ctrl.mem_read;
    assign w_mem_op   = in.ctrl.mem_read | in.ctrl.mem_write;

`ifdef MEM_MISALIGN_TRAP_EN
    always_comb begin
        w_misalign = 1'b0;
        if (w_mem_op) begin
            case (mem_size(in.ctrl.mem_op))
                SZ_HALF: w_misalign = in.alu_result[0];
                SZ_WORD: w_misalign = (in.alu_result[1:0] != 2'b00);
                default: w_misalign = 1'b0;
            endcase
        end
    end
    assign misalign_trap = reset_n & (r_state == IDLE) & w_misalign;
`else
    assign w_misalign    = 1'b0;
    assign misalign_trap = 1'b0;
`endif

    // Store lane enables and replicated write data.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = in.rs2_data;
        case (mem_size(in.ctrl.mem_op))
            SZ_BYTE: begin
                w_be    = 4'b0001 << in.alu_result[1:0];
                w_wdata = {4{in.rs2_data[7:0]}};
            end
            SZ_HALF: begin
                w_be    = 4'b0011 << {in.alu_result[1], 1'b0};
                w_wdata = {2{in.rs2_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_rdata_buf <= '0;
        end else begin
            r_state <= w_state_nx;
            if (r_state == WAIT_RSP && dmem_rsp_valid && hold)
                r_rdata_buf <= dmem_rsp_rdata;
        end
    end

    // Next state and handshake outputs; reset forces the stage transparent.
    always_comb begin
        w_state_nx  = r_state;
        w_req_valid = 1'b0;
        w_stall     = 1'b0;
        w_load_done = 1'b0;
        w_rdata_sel = dmem_rsp_rdata;
        case (r_state)
            IDLE: begin
                if (w_mem_op && !w_misalign) begin
                    w_req_valid = 1'b1;
                    w_stall     = ~(w_is_store & dmem_req_ready);
                    if (dmem_req_ready) begin
                        if (w_is_load)
                            w_state_nx = WAIT_RSP;
                        else if (hold)
                            w_state_nx = DONE;
                    end
                end
            end
            WAIT_RSP: begin
                w_stall = ~dmem_rsp_valid;
                if (dmem_rsp_valid) begin
                    w_load_done = 1'b1;
                    w_state_nx  = hold ? DONE : IDLE;
                end
            end
            DONE: begin
                w_rdata_sel = r_rdata_buf;
                w_load_done = w_is_load;
                if (!hold)
                    w_state_nx = IDLE;
            end
            default: w_state_nx = IDLE;
        endcase
        if (!reset_n) begin
            w_req_valid = 1'b0;
            w_stall     = 1'b0;
            w_load_done = 1'b0;
        end
    end

    load_align u_load_align (
        .i_rdata   (w_rdata_sel),
        .i_addr_lo (in.alu_result[1:0]),
        .i_mem_op  (in.ctrl.mem_op),
        .o_data    (w_load_data)
    );

    always_comb begin
        out            = '0;
        out.alu_result = in.alu_result;
        out.rd_addr    = in.rd_addr;
        out.ctrl       = in.ctrl;
        out.mem_data   = w_load_done ? w_load_data : '0;
        if (misalign_trap)
            out.ctrl.reg_write = 1'b0;
    end

    assign dmem_req_valid = w_req_valid;
    assign mem_stall      = w_stall;
    assign dmem_req_addr  = {in.alu_result[XLEN-1:2], 2'b00};
    assign dmem_req_we    = w_is_store;
    assign dmem_req_be    = w_be;
    assign dmem_req_wdata = w_wdata;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage; bus slave behaviour is scripted per operation.
module tb_mem_access_stage;
    import riscv_pkg::*;

    localparam int K_ALU = 0;
    localparam int K_LD  = 1;
    localparam int K_ST  = 2;

    typedef struct {
        logic [31:0] mem_data;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        we;
        logic        trap;
        logic        reg_write;
        logic [4:0]  rd;
        int          stall_n;
        int          req_n;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    ex_mem_reg_t in;
    logic        hold;
    mem_wb_reg_t out;
    logic        mem_stall;
    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic [31:0] dmem_req_addr;
    logic        dmem_req_we;
    logic [3:0]  dmem_req_be;
    logic [31:0] dmem_req_wdata;
    logic        dmem_rsp_valid;
    logic [31:0] dmem_rsp_rdata;
    logic        misalign_trap;

    int   n_total = 0;
    int   n_bad   = 0;
    exp_t sb[$];

    mem_access_stage #(.XLEN(32)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .in             (in),
        .hold           (hold),
        .out            (out),
        .mem_stall      (mem_stall),
        .dmem_req_valid (dmem_req_valid),
        .dmem_req_ready (dmem_req_ready),
        .dmem_req_addr  (dmem_req_addr),
        .dmem_req_we    (dmem_req_we),
        .dmem_req_be    (dmem_req_be),
        .dmem_req_wdata (dmem_req_wdata),
        .dmem_rsp_valid (dmem_rsp_valid),
        .dmem_rsp_rdata (dmem_rsp_rdata),
        .misalign_trap  (misalign_trap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    function automatic ex_mem_reg_t mk(input int kind, input mem_op_t op, input logic [31:0] a,
                                       input logic [31:0] rs2, input logic [4:0] rd);
        ex_mem_reg_t r;
        r                 = '0;
        r.alu_result      = a;
        r.rs2_data        = rs2;
        r.rd_addr         = rd;
        r.ctrl.mem_op     = op;
        r.ctrl.mem_read   = (kind == K_LD);
        r.ctrl.mem_write  = (kind == K_ST);
        r.ctrl.mem_to_reg = (kind == K_LD);
        r.ctrl.reg_write  = (kind != K_ST);
        return r;
    endfunction

    function automatic exp_t model(input int kind, input mem_op_t op, input logic [31:0] a,
                                   input logic [31:0] rs2, input logic [31:0] rdata,
                                   input logic [4:0] rd, input int rdy_lat);
        exp_t        e;
        logic [31:0] sb8;
        logic [31:0] sh16;
        sb8  = rdata >> {a[1:0], 3'b000};
        sh16 = a[1] ? (rdata >> 16) : rdata;
        e.addr      = a & 32'hFFFF_FFFC;
        e.we        = (kind == K_ST);
        e.rd        = rd;
        e.trap      = 1'b0;
        e.mem_data  = 32'h0;
        case (op)
            MEM_BYTE, MEM_BYTE_U: begin
                e.be    = 4'b0001 << a[1:0];
                e.wdata = {rs2[7:0], rs2[7:0], rs2[7:0], rs2[7:0]};
            end
            MEM_HALF, MEM_HALF_U: begin
                e.be    = a[1] ? 4'b1100 : 4'b0011;
                e.wdata = {rs2[15:0], rs2[15:0]};
`ifdef MEM_MISALIGN_TRAP_EN
                e.trap  = (kind != K_ALU) && a[0];
`endif
            end
            default: begin
                e.be    = 4'b1111;
                e.wdata = rs2;
`ifdef MEM_MISALIGN_TRAP_EN
                e.trap  = (kind != K_ALU) && (a[1:0] != 2'b00);
`endif
            end
        endcase
        if (kind == K_LD) begin
            case (op)
                MEM_BYTE:   e.mem_data = sb8[7] ? (sb8 | 32'hFFFF_FF00) : (sb8 & 32'hFF);
                MEM_BYTE_U: e.mem_data = sb8 & 32'hFF;
                MEM_HALF:   e.mem_data = sh16[15] ? (sh16 | 32'hFFFF_0000) : (sh16 & 32'hFFFF);
                MEM_HALF_U: e.mem_data = sh16 & 32'hFFFF;
                default:    e.mem_data = rdata;
            endcase
        end
        e.reg_write = (kind != K_ST) && !e.trap;
        if (kind == K_ALU || e.trap) begin
            e.mem_data = 32'h0;
            e.stall_n  = 0;
            e.req_n    = 0;
        end else begin
            e.stall_n = (kind == K_LD) ? rdy_lat + 1 : rdy_lat;
            e.req_n   = rdy_lat + 1;
        end
        return e;
    endfunction

    // Run one instruction through the stage; called at posedge+1.
    task automatic do_op(input string nm, input int kind, input mem_op_t op, input logic [31:0] a,
                         input logic [31:0] rs2, input logic [31:0] rdata, input int rdy_lat,
                         input int hold_n);
        exp_t e;
        exp_t got_e;
        int   cyc;
        int   req_c;
        int   stall_c;
        int   acc_c;
        int   rsp_at;
        int   hold_left;
        bit   done;
        logic [4:0] rd;
        rd = 5'($urandom_range(1, 31));
        sb.push_back(model(kind, op, a, rs2, rdata, rd, rdy_lat));
        e         = sb[$];
        in        = mk(kind, op, a, rs2, rd);
        cyc       = 0;
        req_c     = 0;
        stall_c   = 0;
        acc_c     = 0;
        rsp_at    = -1;
        hold_left = 0;
        done      = 1'b0;
        while (!done && cyc < 40) begin
            dmem_req_ready = (cyc >= rdy_lat);
            dmem_rsp_valid = (cyc == rsp_at);
            dmem_rsp_rdata = (cyc == rsp_at) ? rdata : $urandom;
            if (cyc == rsp_at) hold_left = hold_n;
            hold = (hold_left > 0);
            @(negedge clk);
            if (dmem_req_valid) begin
                req_c++;
                check({nm, "_addr"}, dmem_req_addr, e.addr);
                check({nm, "_be"}, 32'(dmem_req_be), 32'(e.be));
                check({nm, "_we"}, 32'(dmem_req_we), 32'(e.we));
                if (e.we) check({nm, "_wdata"}, dmem_req_wdata, e.wdata);
            end
            if (mem_stall) stall_c++;
            if (dmem_req_valid && dmem_req_ready) begin
                acc_c++;
                if (kind == K_LD) rsp_at = cyc + 1;
            end
            if (hold && !mem_stall) begin
                check({nm, "_hold_data"}, out.mem_data, e.mem_data);
                check({nm, "_hold_noreq"}, 32'(dmem_req_valid), 32'h0);
            end
            if (!mem_stall && !hold) begin
                got_e = sb.pop_front();
                check({nm, "_data"}, out.mem_data, got_e.mem_data);
                check({nm, "_alu"}, out.alu_result, a);
                check({nm, "_rd"}, 32'(out.rd_addr), 32'(got_e.rd));
                check({nm, "_rw"}, 32'(out.ctrl.reg_write), 32'(got_e.reg_write));
                check({nm, "_trap"}, 32'(misalign_trap), 32'(got_e.trap));
                done = 1'b1;
            end
            if (hold_left > 0) hold_left--;
            @(posedge clk);
            #1;
            cyc++;
        end
        if (!done) begin
            check({nm, "_timeout"}, 32'h0, 32'h1);
            void'(sb.pop_front());
        end
        check({nm, "_stall_cycles"}, 32'(stall_c), 32'(e.stall_n));
        check({nm, "_req_cycles"}, 32'(req_c), 32'(e.req_n));
        check({nm, "_accepts"}, 32'(acc_c), (e.req_n > 0) ? 32'h1 : 32'h0);
        hold           = 1'b0;
        dmem_rsp_valid = 1'b0;
        dmem_req_ready = 1'b0;
    endtask

    initial begin
        reset_n        = 1'b0;
        hold           = 1'b0;
        dmem_req_ready = 1'b1;
        dmem_rsp_valid = 1'b0;
        dmem_rsp_rdata = 32'h0;
        in             = mk(K_LD, MEM_WORD, 32'h0000_0100, 32'h0, 5'd3);

        // Reset: transparent stage, no request, no stall.
        @(negedge clk);
        check("rst_req", 32'(dmem_req_valid), 32'h0);
        check("rst_stall", 32'(mem_stall), 32'h0);
        check("rst_alu", out.alu_result, 32'h0000_0100);
        check("rst_data", out.mem_data, 32'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        do_op("alu",      K_ALU, MEM_WORD,   32'h0000_1234, 32'h5555_5555, 32'h0, 0, 0);
        do_op("ld_word",  K_LD,  MEM_WORD,   32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0, 0);
        do_op("ld_byte",  K_LD,  MEM_BYTE,   32'h0000_0103, 32'h0, 32'h80FF_FF7F, 0, 0);
        do_op("ld_byteu", K_LD,  MEM_BYTE_U, 32'h0000_0103, 32'h0, 32'h80FF_FF7F, 0, 0);
        do_op("ld_byte0", K_LD,  MEM_BYTE,   32'h0000_0100, 32'h0, 32'h80FF_FF7F, 0, 0);
        do_op("ld_half",  K_LD,  MEM_HALF,   32'h0000_0102, 32'h0, 32'h80FF_FF7F, 0, 0);
        do_op("ld_halfu", K_LD,  MEM_HALF_U, 32'h0000_0100, 32'h0, 32'h80FF_FF7F, 0, 0);
        do_op("st_half",  K_ST,  MEM_HALF,   32'h0000_0202, 32'h1234_ABCD, 32'h0, 3, 0);
        do_op("st_byte",  K_ST,  MEM_BYTE,   32'h0000_0101, 32'hCAFE_F00D, 32'h0, 0, 0);
        do_op("st_word",  K_ST,  MEM_WORD,   32'h0000_0204, 32'h0BAD_C0DE, 32'h0, 1, 0);
        do_op("ld_hold",  K_LD,  MEM_WORD,   32'h0000_0108, 32'h0, 32'h1357_9BDF, 0, 2);
        do_op("ld_holdb", K_LD,  MEM_BYTE,   32'h0000_0109, 32'h0, 32'h0000_8000, 1, 3);
        do_op("ld_slow",  K_LD,  MEM_HALF_U, 32'h0000_010E, 32'h0, 32'hF00D_0001, 2, 0);

        // Reset while a load waits for its response; the late response must be ignored.
        in             = mk(K_LD, MEM_WORD, 32'h0000_0300, 32'h0, 5'd7);
        dmem_req_ready = 1'b1;
        @(negedge clk);
        check("mrst_req_issued", 32'(dmem_req_valid), 32'h1);
        @(posedge clk);
        #1;
        dmem_req_ready = 1'b0;
        reset_n        = 1'b0;
        @(negedge clk);
        check("mrst_req", 32'(dmem_req_valid), 32'h0);
        check("mrst_stall", 32'(mem_stall), 32'h0);
        check("mrst_alu", out.alu_result, 32'h0000_0300);
        @(posedge clk);
        #1;
        reset_n        = 1'b1;
        in             = mk(K_ALU, MEM_WORD, 32'h0000_0044, 32'h0, 5'd8);
        dmem_rsp_valid = 1'b1;
        dmem_rsp_rdata = 32'hA5A5_A5A5;
        @(negedge clk);
        check("late_rsp_stall", 32'(mem_stall), 32'h0);
        check("late_rsp_data", out.mem_data, 32'h0);
        check("late_rsp_req", 32'(dmem_req_valid), 32'h0);
        @(posedge clk);
        #1;
        dmem_rsp_valid = 1'b0;

        do_op("ld_after_rst", K_LD, MEM_BYTE_U, 32'h0000_0302, 32'h0, 32'h0011_2233, 0, 0);
        do_op("ld_mis_word",  K_LD, MEM_WORD,   32'h0000_0101, 32'h0, 32'hFEED_FACE, 0, 0);
        do_op("ld_mis_half",  K_LD, MEM_HALF,   32'h0000_0203, 32'h0, 32'h9876_5432, 0, 0);
        do_op("st_mis_word",  K_ST, MEM_WORD,   32'h0000_0206, 32'h7777_1111, 32'h0, 0, 0);

        check("sb_empty", 32'(sb.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
